// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, same-cycle write bypass
// and a per-register busy scoreboard. Read latency 1 cycle; no backpressure.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       resv_en,
  input  logic [ADDR_W-1:0]          resv_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              wr_ok, resv_ok;

  logic [ADDR_W-1:0] rd_addr_w  [NUM_RD];
  logic [DATA_W-1:0] rd_data_q  [NUM_RD];
  logic [DATA_W-1:0] rd_data_d  [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_q, rd_busy_d, rd_valid_q;

  assign wr_ok   = wr_en   && !((ZERO_REG != 0) && (wr_addr   == '0));
  assign resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));

  // Reservation is applied after the write clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)   busy_d[wr_addr]   = 1'b0;
    if (resv_ok) busy_d[resv_addr] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_d[p] = rd_data_q[p];
      rd_busy_d[p] = rd_busy_q[p];
      if (rd_en[p]) begin
        if ((ZERO_REG != 0) && (rd_addr_w[p] == '0)) begin
          rd_data_d[p] = '0;
          rd_busy_d[p] = 1'b0;
        end else begin
          rd_data_d[p] = (wr_ok && (wr_addr == rd_addr_w[p])) ? wr_data : mem_q[rd_addr_w[p]];
          rd_busy_d[p] = busy_d[rd_addr_w[p]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) mem_q[n] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) mem_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= '0;
      rd_busy_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= rd_data_d[p];
      rd_busy_q  <= rd_busy_d;
      rd_valid_q <= rd_en;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign rd_addr_w[g]                  = rd_addr[g*ADDR_W +: ADDR_W];
    assign rd_data[g*DATA_W +: DATA_W]   = rd_data_q[g];
  end

  assign rd_busy  = rd_busy_q;
  assign rd_valid = rd_valid_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed checks on the default and ZERO_REG=0
// builds, plus a randomised model comparison on a 16-bit, 8-entry, 4-port build.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the default (a_) and ZERO_REG=0 (b_) instances
  logic        rst_a;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        resv_en;
  logic [4:0]  resv_addr;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy, a_rd_valid, b_rd_valid;
  logic [31:0] a_busy_vec, b_busy_vec;

  logic        s_rst, s_wr_en, s_resv_en;
  logic [2:0]  s_wr_addr, s_resv_addr;
  logic [15:0] s_wr_data;
  logic [3:0]  s_rd_en, s_rd_busy, s_rd_valid;
  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic [7:0]  s_busy_vec;

  regfile_mp u_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .rd_valid(a_rd_valid), .resv_en(resv_en), .resv_addr(resv_addr), .busy_vec(a_busy_vec)
  );

  regfile_mp #(.ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .rd_valid(b_rd_valid), .resv_en(resv_en), .resv_addr(resv_addr), .busy_vec(b_busy_vec)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_s (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .rd_valid(s_rd_valid), .resv_en(s_resv_en), .resv_addr(s_resv_addr), .busy_vec(s_busy_vec)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  // sel: 0-6 instance a, 10-16 instance b, 20-32 sweep instance
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  return a_rd_data[31:0];
      1:  return a_rd_data[63:32];
      2:  return 32'(a_rd_busy[0]);
      3:  return 32'(a_rd_busy[1]);
      4:  return 32'(a_rd_valid[0]);
      5:  return 32'(a_rd_valid[1]);
      6:  return a_busy_vec;
      10: return b_rd_data[31:0];
      11: return b_rd_data[63:32];
      12: return 32'(b_rd_busy[0]);
      13: return 32'(b_rd_busy[1]);
      14: return 32'(b_rd_valid[0]);
      15: return 32'(b_rd_valid[1]);
      16: return b_busy_vec;
      32: return 32'(s_busy_vec);
      default: begin
        if (sel >= 20 && sel < 24) return 32'(s_rd_data[(sel-20)*16 +: 16]);
        if (sel >= 24 && sel < 28) return 32'(s_rd_busy[sel-24]);
        if (sel >= 28 && sel < 32) return 32'(s_rd_valid[sel-28]);
        return 32'hBAD0_BAD0;
      end
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    rst_a = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; resv_en = 1'b0; resv_addr = '0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p*5 +: 5] = 5'(a);
  endtask

  task automatic resv(input int a);
    resv_en = 1'b1; resv_addr = 5'(a);
  endtask

  // Reference model for the sweep instance
  logic [15:0] m_mem [8];
  logic [7:0]  m_busy;
  logic [15:0] m_rd [4];
  logic [3:0]  m_rb, m_rv;

  task automatic sweep_cycle();
    logic [7:0] nb;
    logic       wok, rok;
    logic [2:0] a;
    if (s_rst) begin
      for (int n = 0; n < 8; n++) m_mem[n] = '0;
      for (int p = 0; p < 4; p++) m_rd[p] = '0;
      m_busy = '0; m_rb = '0; m_rv = '0;
    end else begin
      wok = s_wr_en && (s_wr_addr != 3'd0);
      rok = s_resv_en && (s_resv_addr != 3'd0);
      nb = m_busy;
      if (wok) nb[s_wr_addr] = 1'b0;
      if (rok) nb[s_resv_addr] = 1'b1;
      for (int p = 0; p < 4; p++) begin
        if (s_rd_en[p]) begin
          a = s_rd_addr[p*3 +: 3];
          if (a == 3'd0) begin
            m_rd[p] = '0;
            m_rb[p] = 1'b0;
          end else begin
            m_rd[p] = (wok && s_wr_addr == a) ? s_wr_data : m_mem[a];
            m_rb[p] = nb[a];
          end
        end
      end
      m_rv = s_rd_en;
      if (wok) m_mem[s_wr_addr] = s_wr_data;
      m_busy = nb;
    end
    for (int p = 0; p < 4; p++) begin
      push($sformatf("sw_data%0d", p), 20 + p, 32'(m_rd[p]));
      push($sformatf("sw_busy%0d", p), 24 + p, 32'(m_rb[p]));
      push($sformatf("sw_valid%0d", p), 28 + p, 32'(m_rv[p]));
    end
    push("sw_busy_vec", 32, 32'(m_busy));
    tick();
  endtask

  initial begin
    idle();
    rst_a = 1'b1;
    s_rst = 1'b1; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd_en = '0; s_rd_addr = '0; s_resv_en = 1'b0; s_resv_addr = '0;
    for (int n = 0; n < 8; n++) m_mem[n] = '0;
    for (int p = 0; p < 4; p++) m_rd[p] = '0;
    m_busy = '0; m_rb = '0; m_rv = '0;

    push("rst_data0", 0, 32'h0); push("rst_valid0", 4, 32'h0);
    push("rst_valid1", 5, 32'h0); push("rst_busy_vec", 6, 32'h0);
    tick();

    // Reset overrides a same-cycle read and reservation, and clears memory
    idle(); wr(16, 32'd5); tick();
    idle(); wr(17, 32'd35); tick();
    idle(); rst_a = 1'b1; rd(0, 16); rd(1, 17); resv(4);
    push("rstcyc_valid0", 4, 32'h0); push("rstcyc_valid1", 5, 32'h0);
    push("rstcyc_busy_vec", 6, 32'h0);
    tick();
    idle(); rd(0, 16); rd(1, 17);
    push("rstclr_data0", 0, 32'h0); push("rstclr_data1", 1, 32'h0);
    push("rstclr_busy0", 2, 32'h0); push("rstclr_busy1", 3, 32'h0);
    push("rstclr_valid0", 4, 32'h1); push("rstclr_valid1", 5, 32'h1);
    push("rstclr_busy_vec", 6, 32'h0);
    tick();

    idle(); wr(3, 32'hDEADBEEF); tick();
    idle(); wr(5, 32'h0000_1234); rd(1, 5);
    push("byp_r5_data1", 1, 32'h0000_1234);
    tick();
    idle(); rd(0, 3);
    push("wr_rd_data0", 0, 32'hDEADBEEF); push("wr_rd_valid0", 4, 32'h1);
    push("idle_valid1", 5, 32'h0); push("idle_hold_data1", 1, 32'h0000_1234);
    tick();

    idle(); wr(7, 32'h11); tick();
    idle(); wr(7, 32'h22); rd(0, 7); rd(1, 7);
    push("byp_data0", 0, 32'h22); push("byp_data1", 1, 32'h22);
    tick();
    idle(); rd(0, 7); rd(1, 7);
    push("after_byp_data0", 0, 32'h22); push("after_byp_data1", 1, 32'h22);
    tick();

    idle(); wr(0, 32'hFFFFFFFF); rd(0, 0); rd(1, 0); resv(0);
    push("zero_data0", 0, 32'h0); push("zero_data1", 1, 32'h0);
    push("zero_busy0", 2, 32'h0); push("zero_busy_vec", 6, 32'h0);
    push("nozero_data0", 10, 32'hFFFFFFFF); push("nozero_busy0", 12, 32'h1);
    push("nozero_busy_vec", 16, 32'h1);
    tick();
    idle(); rd(0, 0);
    push("zero_reread", 0, 32'h0); push("nozero_reread", 10, 32'hFFFFFFFF);
    tick();

    idle(); resv(9);
    push("resv_busy_vec", 6, 32'h0000_0200);
    tick();
    idle(); rd(0, 9);
    push("resv_rd_busy0", 2, 32'h1);
    tick();
    idle(); wr(9, 32'hAA); rd(1, 9);
    push("clr_busy_vec", 6, 32'h0); push("clr_rd_busy1", 3, 32'h0);
    push("clr_data1", 1, 32'hAA);
    tick();
    idle(); wr(9, 32'hBB); resv(9); rd(0, 9);
    push("setclr_busy_vec", 6, 32'h0000_0200); push("setclr_busy0", 2, 32'h1);
    push("setclr_data0", 0, 32'hBB);
    tick();
    idle(); resv(12); rd(1, 12);
    push("resv_same_busy1", 3, 32'h1); push("resv_same_vec", 6, 32'h0000_1200);
    tick();
    idle(); wr(9, 32'hCC); rd(0, 9); rd(1, 12);
    push("mix_data0", 0, 32'hCC); push("mix_busy0", 2, 32'h0);
    push("mix_busy1", 3, 32'h1); push("mix_vec", 6, 32'h0000_1000);
    tick();
    idle();

    // Sweep instance: preload r1..r7, then random traffic with reset pulses
    for (int i = 1; i < 8; i++) begin
      s_rst = 1'b0; s_wr_en = 1'b1; s_wr_addr = 3'(i);
      s_wr_data = 16'h1000 + 16'(i * 16'h0111);
      s_rd_en = 4'hF; s_rd_addr = 12'($urandom);
      s_resv_en = 1'b0; s_resv_addr = '0;
      sweep_cycle();
    end
    for (int c = 0; c < 1000; c++) begin
      s_rst       = ($urandom_range(0, 99) < 3);
      s_wr_en     = 1'($urandom_range(0, 1));
      s_wr_addr   = 3'($urandom_range(0, 7));
      s_wr_data   = 16'($urandom);
      s_rd_en     = 4'($urandom);
      s_rd_addr   = 12'($urandom);
      s_resv_en   = ($urandom_range(0, 3) == 0);
      s_resv_addr = 3'($urandom_range(0, 7));
      sweep_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parameterised multi-read-port register file with a built-in write-reservation scoreboard, the next generation of the CPU's 32×32 register file. It provides NUM_RD registered read ports with same-cycle write-through bypass, one write port, a hardwired-zero register 0, and a synchronous clear. It sits between decode (read and reservation requests) and writeback (write port), so hazard detection can use the per-register busy bits.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations; 0 = register 0 is ordinary
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  port i address in bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port i data in bits [i*DATA_W +: DATA_W], registered
- rd_busy  out  NUM_RD  port i: addressed register has an outstanding reservation, registered
- rd_valid  out  NUM_RD  port i: rd_data/rd_busy updated by a read last cycle
- resv_en  in  1  reserve a destination register (sets its busy bit)
- resv_addr  in  ADDR_W  register to reserve
- busy_vec  out  2**ADDR_W  raw scoreboard, bit n = register n busy

## Operation
- Storage: 2**ADDR_W × DATA_W flops. Reads are not combinational.
- Write: on a rising edge with wr_en=1 and rst=0, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. When ZERO_REG=1, a write to address 0 is dropped and mem[0] stays 0.
- Read: on a rising edge with rd_en[i]=1, rd_data[i] and rd_busy[i] are captured and rd_valid[i] <= 1. With rd_en[i]=0, rd_data[i] and rd_busy[i] hold and rd_valid[i] <= 0.
- Bypass: if wr_en=1 and wr_addr==rd_addr[i] (a legal write) on the same edge, rd_data[i] captures wr_data, not the old contents. Ports bypass independently. Identical addresses on several ports return identical data.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 and rd_busy 0, regardless of a same-cycle write.
- Scoreboard: on an edge with resv_en=1, busy[resv_addr] <= 1. With ZERO_REG=1, a reservation of address 0 is ignored.
- Set/clear on the same register in the same cycle: reservation wins and busy ends at 1 (a new in-flight producer).
- rd_busy[i] captures the post-edge value of busy[rd_addr[i]], with the same-cycle write clear and reservation set already applied.
- busy_vec is a direct (combinational) view of the busy flops.

## Timing
- Read latency: 1 cycle from rd_en/rd_addr to rd_data/rd_busy/rd_valid.
- Write visible to a read issued in the same cycle (bypass), and to all later reads.
- Reservation: busy_vec reflects it 1 cycle after resv_en; a same-cycle read's rd_busy already shows it.
- Reset: when rst=1 at an edge, all of the following apply and override every same-cycle write, reservation and read:
  - all mem entries <= 0
  - all busy <= 0
  - rd_data <= 0, rd_busy <= 0, rd_valid <= 0
- Reset mid-operation: a read issued in the reset cycle yields rd_valid=0 next cycle. The first cycle with rst=0 behaves normally.
- No backpressure. Every request completes in one cycle.

## Test plan
- Reset clear: write 5→r16, 35→r17, then assert rst 1 cycle, then read r16/r17 on ports 0/1 → rd_data=0/0, rd_busy=0/0, busy_vec=0.
- Write then read: write 0xDEADBEEF→r3; next cycle read r3 on port 0 → following cycle rd_data[0]=0xDEADBEEF, rd_valid[0]=1; port 1 idle → rd_valid[1]=0, data held.
- Bypass: r7 holds 0x11; same cycle wr r7=0x22 and read r7 on both ports → both rd_data=0x22; next-cycle read → 0x22.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF→r0 with simultaneous read r0; also resv r0 → rd_data=0, rd_busy=0, busy_vec[0]=0. With ZERO_REG=0 the same sequence → rd_data=0xFFFFFFFF.
- Scoreboard:
  - resv r9 → busy_vec[9]=1 next cycle
  - read r9 → rd_busy=1
  - write r9 → busy_vec[9]=0
  - same-cycle write r9 and resv r9 → busy_vec[9]=1, mem[r9] updated
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=4; write distinct values to r1..r7, read all four ports each cycle, compare against a reference model for 1000 random cycles including random rst pulses.
